mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_step.sv | 40 ++++
 rtl/mul_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states, default width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational radix-2 iteration: shift-add multiply or restoring divide.
// The divide path exists only when MDU_DIV_EN is defined.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
`ifdef MDU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem;
  logic             ge;
`endif

  always_comb begin
    // {acc,q} shifts right one place; the carry of the add enters acc's MSB
    sum   = {1'b0, acc_i} + {1'b0, m_i & {WIDTH{q_i[0]}}};
    acc_o = sum[WIDTH:1];
    q_o   = {sum[0], q_i[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    // remainder stays below the divisor, so a successful trial fits WIDTH bits
    shifted = {acc_i, q_i[WIDTH-1]};
    ge      = shifted >= {1'b0, m_i};
    rem     = shifted[WIDTH-1:0] - m_i;
    if (div_i) begin
      acc_o = ge ? rem : shifted[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers (IDLE/RUN/FIX FSM).
// Divider is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU are reserved.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero,
  output logic             illegal
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, q_q, m_q, hi_q, lo_q;
  logic             neg_q, busy_q, done_q, illegal_q;

  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_acc, step_q, hi_d, lo_d;

`ifdef MDU_DIV_EN
  logic div_q, rneg_q, dz_q, divzero_q;
  assign divzero = divzero_q;
`else
  assign divzero = 1'b0;
`endif

  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg  = sgn_op & a[WIDTH-1];
  assign b_neg  = sgn_op & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
    .div_i (div_q),
`endif
    .acc_i (acc_q),
    .q_i   (q_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q)
  );

  // Sign correction of the magnitude result; divide-by-zero overrides the quotient
  always_comb begin
    {hi_d, lo_d} = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
`ifdef MDU_DIV_EN
    if (div_q) begin
      hi_d = rneg_q ? -acc_q : acc_q;
      lo_d = dz_q ? '1 : (neg_q ? -q_q : q_q);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      divzero_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                acc_q   <= '0;
                m_q     <= a_mag;
                q_q     <= b_mag;
                neg_q   <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                div_q     <= 1'b0;
                divzero_q <= 1'b0;
`endif
              end
`ifdef MDU_DIV_EN
              OP_DIV, OP_DIVU: begin
                state_q   <= RUN;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                acc_q     <= '0;
                m_q       <= b_mag;
                q_q       <= a_mag;
                neg_q     <= a_neg ^ b_neg;
                rneg_q    <= a_neg;
                dz_q      <= (b == '0);
                div_q     <= 1'b1;
                divzero_q <= 1'b0;
              end
`endif
              OP_MTHI: begin
                hi_q <= a;
`ifdef MDU_DIV_EN
                divzero_q <= 1'b0;
`endif
              end
              OP_MTLO: begin
                lo_q <= a;
`ifdef MDU_DIV_EN
                divzero_q <= 1'b0;
`endif
              end
              default: illegal_q <= 1'b1;
            endcase
          end
        end
        RUN: begin
          acc_q <= step_acc;
          q_q   <= step_q;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef MDU_DIV_EN
          if (div_q) divzero_q <= dz_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed corner cases plus
// random commands against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, divzero, illegal;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;
  logic         exp_ill = 1'b0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .divzero (divzero),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Architectural effect of one accepted command, from plain integer arithmetic
  task automatic model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint      x, y;
    logic [63:0] t;
    exp_ill = 1'b0;
    case (mop)
      3'd0, 3'd1: begin
        if (mop == 3'd0) begin
          x = longint'($signed(ma));
          y = longint'($signed(mb));
        end else begin
          x = longint'({32'b0, ma});
          y = longint'({32'b0, mb});
        end
        t = x * y;
        {exp_hi, exp_lo} = t;
        exp_dz = 1'b0;
      end
      3'd2, 3'd3: begin
        if (!DIV_EN) exp_ill = 1'b1;
        else if (mb == '0) begin
          exp_lo = '1;
          exp_hi = ma;
          exp_dz = 1'b1;
        end else begin
          if (mop == 3'd2) begin
            x = longint'($signed(ma));
            y = longint'($signed(mb));
          end else begin
            x = longint'({32'b0, ma});
            y = longint'({32'b0, mb});
          end
          t = x / y;
          exp_lo = t[W-1:0];
          t = x % y;
          exp_hi = t[W-1:0];
          exp_dz = 1'b0;
        end
      end
      3'd4: begin exp_hi = ma; exp_dz = 1'b0; end
      3'd5: begin exp_lo = ma; exp_dz = 1'b0; end
      default: exp_ill = 1'b1;
    endcase
  endtask

  // Called at #1 after an edge; that next edge is the accept edge. Returns at #1
  // after the last edge it consumed, so a following call tests back-to-back accept.
  // inj>0 raises an MTHI start before edge inj of the run, which must be ignored.
  task automatic do_cmd(input logic [2:0] cop, input logic [W-1:0] ca, input logic [W-1:0] cb,
                        input int inj);
    logic [W-1:0] h0, l0;
    logic         iter, ok;
    h0   = exp_hi;
    l0   = exp_lo;
    iter = (cop <= 3'd1) || (((cop == 3'd2) || (cop == 3'd3)) && DIV_EN);
    start = 1'b1; op = cop; a = ca; b = cb;
    @(posedge clk); #1;
    start = 1'b0;
    model(cop, ca, cb);
    if (iter) begin
      chk("busy_accept", busy, 1'b1);
      chk("divzero_accept", divzero, 1'b0);
      chk("illegal_accept", illegal, 1'b0);
      ok = 1'b1;
      for (int e = 1; e <= int'(W); e++) begin
        if (inj != 0 && e == inj) begin start = 1'b1; op = 3'd4; a = 32'h1234; end
        @(posedge clk); #1;
        if (inj != 0 && e == inj) start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0 || hi !== h0 || lo !== l0) ok = 1'b0;
      end
      chk("run_window", ok, 1'b1);
      @(posedge clk); #1;
      chk("done_pulse", done, 1'b1);
      chk("busy_end", busy, 1'b0);
      chk("hi_result", hi, exp_hi);
      chk("lo_result", lo, exp_lo);
      chk("divzero_result", divzero, exp_dz);
    end else begin
      chk("busy_imm", busy, 1'b0);
      chk("done_imm", done, 1'b0);
      chk("illegal_imm", illegal, exp_ill);
      chk("hi_imm", hi, exp_hi);
      chk("lo_imm", lo, exp_lo);
      chk("divzero_imm", divzero, exp_dz);
      if (exp_ill) begin
        @(posedge clk); #1;
        chk("illegal_clear", illegal, 1'b0);
      end
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0] rop;
    logic       seen;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_divzero", divzero, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    do_cmd(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    do_cmd(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
    do_cmd(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    do_cmd(3'd3, 32'd100, 32'd0, 0);
    do_cmd(3'd1, 32'd2, 32'd3, 0);
    do_cmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_cmd(3'd1, 32'd7, 32'd9, 5);
    do_cmd(3'd4, 32'h1234, 32'd0, 0);
    do_cmd(3'd6, 32'hDEAD_BEEF, 32'd1, 0);
    do_cmd(3'd7, 32'h0BAD_F00D, 32'd2, 0);
    do_cmd(3'd5, 32'hCAFE_0001, 32'd0, 0);

    // Reset in the middle of an iterative operation
    rop = DIV_EN ? 3'd3 : 3'd1;
    start = 1'b1; op = rop; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 1'b0);
    do_cmd(3'd1, 32'd5, 32'd6, 0);

    for (int n = 0; n < 40; n++) begin
      do_cmd(3'($urandom_range(0, 7)), pick(), pick(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
